load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multicycle load/store unit between the CPU datapath's memory-access state and a word-organised data memory with fixed read latency.
- Accepts one request at a time over a valid/ready handshake.
- Generates byte enables and lane-replicated write data for stores; extracts, sign-extends or zero-extends load data.
- Flags misaligned or unsupported accesses without touching memory.
- Returns exactly one response per accepted request.

Parameters:
- ADDR_WIDTH, 32, byte-address width from the datapath.
- MEM_AW, 10, word-address width to memory; mem_addr = addr[MEM_AW+1:2].
- READ_LATENCY, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_WIDTH  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write strobe; only high together with mem_en.
- mem_be  out  4  byte enables.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read word, valid READ_LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, mem_en 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid at edge T, latch write/funct3/addr/wdata.
  - Faulting request goes to RESP; otherwise goes to ISSUE.
- ISSUE (one cycle):
  - mem_en = 1, mem_addr/mem_be/mem_wdata driven from latched request, mem_we = latched write.
  - Store goes to RESP. Load goes to WAIT with counter = READ_LATENCY-1.
- WAIT:
  - Counter decrements each cycle.
  - When counter = 0 and the cycle is READ_LATENCY cycles after ISSUE, mem_rdata is sampled and extended into resp_rdata; state goes to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Latency from accept edge to resp_valid cycle:
  - fault: 1 cycle.
  - store: 2 cycles.
  - load: 2+READ_LATENCY cycles.
- Throughput: a new request is accepted at the earliest in the cycle after RESP; no overlap.
- Funct3 legality:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal -> fault.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; else fault.
- Fault response: no mem_en, resp_rdata 0.
- Store byte enables:
  - SB: mem_be = 1<<addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 1100 : 0011, mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111.
- Loads: mem_be = 1111; the lane is selected by addr[1:0], then sign/zero extended per funct3.
- mem_en/mem_we are combinational from state==ISSUE and gated by !reset. Reset asserted during ISSUE therefore suppresses the write.
- Reset in any state: next cycle IDLE with reset values; in-flight response is discarded and any late mem_rdata is ignored.
- req_valid held across RESP is not accepted until IDLE.
- Upper address bits above MEM_AW+1 are ignored (wrap).

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants (F3_LB..F3_LHU, F3_SB..F3_SW).
  - LSU state encoding.
  - lane-width typedef.
- One combinational sub-module lsu_lane_align: byte enables, write replication, fault decode, load extraction/extension. The FSM stays in load_store_unit.

Test Plan:
- Memory word 1 = 0x884422F1, READ_LATENCY=1:
  - LB addr 0x4 -> resp_rdata 0xFFFFFFF1, resp_valid 3 cycles after accept.
  - LBU addr 0x7 -> 0x00000088.
  - LH addr 0x6 -> 0xFFFF8844.
  - LW addr 0x4 -> 0x884422F1.
- SB wdata 0x123456AB addr 0x9 -> single mem_en cycle, mem_we 1, mem_addr 2, mem_be 0010, mem_wdata 0xABABABAB. Subsequent LW addr 0x8 shows only byte 1 changed.
- LW addr 0x6 and SH addr 0x3 -> resp_fault 1 one cycle after accept, mem_en never high, resp_rdata 0.
- req_funct3=011 load and 100 store -> resp_fault 1, no memory access.
- READ_LATENCY=3 load: assert reset in second WAIT cycle -> no resp_valid. The next cycle is IDLE with req_ready 1, and the next LW returns correct data 5 cycles after accept.
- Back-to-back SW/LW with req_valid held high -> second request accepted the cycle after the first resp_valid; exactly one resp_valid per request.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store path: RV32I funct3 codes, LSU FSM states
// and the access-width classification used by the lane aligner.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } lsu_state_t;

   typedef enum logic [1:0] {
      LANE_BYTE,
      LANE_HALF,
      LANE_WORD,
      LANE_NONE
   } lane_width_t;

   // Access width is encoded in funct3[1:0] for both loads and stores.
   function automatic lane_width_t lane_width(input logic [2:0] funct3);
      lane_width_t w;
      case (funct3[1:0])
         2'b00:   w = LANE_BYTE;
         2'b01:   w = LANE_HALF;
         2'b10:   w = LANE_WORD;
         default: w = LANE_NONE;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: access legality, store byte enables and replicated
// write data, and load lane extraction with sign/zero extension.
module lsu_lane_align
   import riscv_mem_pkg::*;
(
   input  logic        write,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        fault,
   output logic [31:0] rdata_ext
);

   lane_width_t width;
   logic [7:0]  byte_lane [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic        legal;
   logic        misaligned;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
   end

   assign width    = lane_width(funct3);
   assign sel_byte = byte_lane[addr_lo];
   assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      if (write) begin
         legal = funct3 inside {F3_SB, F3_SH, F3_SW};
      end else begin
         legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      end
      misaligned = 1'b0;
      case (width)
         LANE_HALF: misaligned = addr_lo[0];
         LANE_WORD: misaligned = |addr_lo;
         default:   misaligned = 1'b0;
      endcase
      fault = !legal || misaligned;
   end

   // Loads always fetch the full word; only stores narrow the enables.
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      if (write) begin
         case (width)
            LANE_BYTE: begin
               be        = 4'b0001 << addr_lo;
               wdata_rep = {4{wdata[7:0]}};
            end
            LANE_HALF: begin
               be        = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
               be        = 4'b1111;
               wdata_rep = wdata;
            end
         endcase
      end
   end

   always_comb begin
      case (funct3)
         F3_LB:   rdata_ext = {{24{sel_byte[7]}}, sel_byte};
         F3_LH:   rdata_ext = {{16{sel_half[15]}}, sel_half};
         F3_LW:   rdata_ext = rdata;
         F3_LBU:  rdata_ext = {24'h0, sel_byte};
         F3_LHU:  rdata_ext = {16'h0, sel_half};
         default: rdata_ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: one request at a time, fixed-latency word memory,
// one response per accepted request; faulting accesses never reach memory.
module load_store_unit
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_AW       = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_fault,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

   lsu_state_t  state_reg;
   logic        write_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  addr_lo_reg;
   logic [1:0]  cnt_reg;

   logic        sel_write;
   logic [2:0]  sel_funct3;
   logic [1:0]  sel_addr_lo;
   logic [3:0]  align_be;
   logic [31:0] align_wdata;
   logic        align_fault;
   logic [31:0] align_rdata;
   logic        unused_addr_bits;

   // Upper address bits wrap onto the memory; they are intentionally dropped.
   assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:MEM_AW+2];

   // In IDLE the aligner decodes the incoming request; afterwards it works on the
   // latched copy so load extraction sees the original funct3 and lane.
   assign sel_write   = (state_reg == ST_IDLE) ? req_write     : write_reg;
   assign sel_funct3  = (state_reg == ST_IDLE) ? req_funct3    : funct3_reg;
   assign sel_addr_lo = (state_reg == ST_IDLE) ? req_addr[1:0] : addr_lo_reg;

   lsu_lane_align u_lane_align (
      .write     (sel_write),
      .funct3    (sel_funct3),
      .addr_lo   (sel_addr_lo),
      .wdata     (req_wdata),
      .rdata     (mem_rdata),
      .be        (align_be),
      .wdata_rep (align_wdata),
      .fault     (align_fault),
      .rdata_ext (align_rdata)
   );

   // Gated by reset so a reset landing on the ISSUE cycle cancels the write.
   assign mem_en = (state_reg == ST_ISSUE) && !reset;
   assign mem_we = mem_en && write_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'h0;
         resp_fault  <= 1'b0;
         mem_be      <= 4'h0;
         mem_addr    <= '0;
         mem_wdata   <= 32'h0;
         write_reg   <= 1'b0;
         funct3_reg  <= 3'h0;
         addr_lo_reg <= 2'h0;
         cnt_reg     <= 2'h0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  write_reg   <= req_write;
                  funct3_reg  <= req_funct3;
                  addr_lo_reg <= req_addr[1:0];
                  resp_rdata  <= 32'h0;
                  req_ready   <= 1'b0;
                  if (align_fault) begin
                     state_reg  <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                  end else begin
                     state_reg <= ST_ISSUE;
                     mem_addr  <= req_addr[MEM_AW+1:2];
                     mem_be    <= align_be;
                     mem_wdata <= align_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               if (write_reg) begin
                  state_reg  <= ST_RESP;
                  resp_valid <= 1'b1;
               end else begin
                  state_reg <= ST_WAIT;
                  cnt_reg   <= WAIT_INIT;
               end
            end
            ST_WAIT: begin
               if (cnt_reg == 2'd0) begin
                  resp_rdata <= align_rdata;
                  resp_valid <= 1'b1;
                  state_reg  <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 2'd1;
               end
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               req_ready  <= 1'b1;
               state_reg  <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two units (read latency 1 and 3) driven with directed and
// random requests; a byte-level memory model predicts responses and accesses.
module tb_load_store_unit;
   import riscv_mem_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
      int          cyc;
   } resp_exp_t;

   typedef struct packed {
      logic [9:0]  addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          cyc;
   } mem_exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d: got 0x%08h, expected 0x%08h", name, inst, act, exp);
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int RL      = (gi == 0) ? 1 : 3;
      localparam int RST_OFF = (RL > 1) ? 3 : 2;

      logic        reset, req_valid, req_ready, req_write;
      logic [2:0]  req_funct3;
      logic [31:0] req_addr, req_wdata;
      logic        resp_valid, resp_fault, mem_en, mem_we;
      logic [31:0] resp_rdata, mem_wdata, mem_rdata;
      logic [3:0]  mem_be;
      logic [9:0]  mem_addr;

      load_store_unit #(.ADDR_WIDTH(32), .MEM_AW(10), .READ_LATENCY(RL)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (req_valid),
         .req_ready  (req_ready),
         .req_write  (req_write),
         .req_funct3 (req_funct3),
         .req_addr   (req_addr),
         .req_wdata  (req_wdata),
         .resp_valid (resp_valid),
         .resp_rdata (resp_rdata),
         .resp_fault (resp_fault),
         .mem_en     (mem_en),
         .mem_we     (mem_we),
         .mem_be     (mem_be),
         .mem_addr   (mem_addr),
         .mem_wdata  (mem_wdata),
         .mem_rdata  (mem_rdata)
      );

      // Word memory with an RL-deep read pipeline.
      logic [31:0] mem_word [1024];
      logic [31:0] rd_pipe  [4];
      always @(posedge clk) begin
         if (mem_en) begin
            rd_pipe[0] <= mem_word[mem_addr];
            if (mem_we)
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) mem_word[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
         for (int s = 1; s < 4; s++) rd_pipe[s] <= rd_pipe[s-1];
      end
      assign mem_rdata = rd_pipe[RL-1];

      logic [7:0] ref_mem [4096];
      resp_exp_t  resp_q [$];
      mem_exp_t   mem_q  [$];
      int         mem_seen = 0, mem_expected = 0;
      int         last_accept = 0, last_lat = 0;
      bit         prev_held = 1'b0;
      bit         done = 1'b0;

      always @(negedge clk) begin : mon
         resp_exp_t e;
         mem_exp_t  m;
         if (resp_valid) begin
            if (resp_q.size() == 0) begin
               check("resp_unexpected", gi, 32'(resp_q.size()), 32'd1);
            end else begin
               e = resp_q.pop_front();
               $display("[%0d] inst%0d resp rdata=%08h fault=%0d exp=%08h/%0d", cyc, gi,
                        resp_rdata, resp_fault, e.rdata, e.fault);
               check("resp_rdata", gi, resp_rdata, e.rdata);
               check("resp_fault", gi, 32'(resp_fault), 32'(e.fault));
               check("resp_cycle", gi, 32'(cyc), 32'(e.cyc));
            end
         end
         if (mem_we && !mem_en) check("we_without_en", gi, 32'(mem_en), 32'd1);
         if (mem_en) begin
            mem_seen++;
            if (mem_q.size() == 0) begin
               check("mem_unexpected", gi, 32'(mem_q.size()), 32'd1);
            end else begin
               m = mem_q.pop_front();
               check("mem_addr", gi, 32'(mem_addr), 32'(m.addr));
               check("mem_we", gi, 32'(mem_we), 32'(m.we));
               check("mem_be", gi, 32'(mem_be), 32'(m.be));
               if (m.we) check("mem_wdata", gi, mem_wdata, m.wdata);
               check("mem_cycle", gi, 32'(cyc), 32'(m.cyc));
            end
         end
      end

      task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit hold);
         int a, sz, lat, n;
         bit legal, fault;
         logic [31:0] exp_rd, be_v;
         resp_exp_t r;
         mem_exp_t  m;
         @(negedge clk);
         req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
         n = 0;
         while (!req_ready && n < 64) begin @(negedge clk); n++; end
         if (!req_ready) begin
            check("accept_timeout", gi, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
         end
         a     = int'(addr[11:0]);
         sz    = 1 << f3[1:0];
         legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
         fault = !legal || (a % sz != 0);
         exp_rd = 32'h0;
         if (!fault && !wr) begin
            for (int b = 0; b < sz; b++) exp_rd |= 32'(ref_mem[a+b]) << (8*b);
            if (!f3[2] && sz < 4 && exp_rd[8*sz-1]) exp_rd |= ~((32'h1 << (8*sz)) - 32'h1);
         end
         if (!fault && wr)
            for (int b = 0; b < sz; b++) ref_mem[a+b] = wd[8*b +: 8];
         lat = fault ? 1 : (wr ? 2 : 2 + RL);
         if (prev_held) check("b2b_accept", gi, 32'(cyc), 32'(last_accept + last_lat + 1));
         r.rdata = exp_rd; r.fault = fault; r.cyc = cyc + lat;
         resp_q.push_back(r);
         if (!fault) begin
            be_v    = ((32'h1 << sz) - 32'h1) << (a % 4);
            m.addr  = 10'(a >> 2);
            m.we    = wr;
            m.be    = wr ? be_v[3:0] : 4'hF;
            m.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
            m.cyc   = cyc + 1;
            mem_q.push_back(m);
            mem_expected++;
         end
         last_accept = cyc;
         last_lat    = lat;
         prev_held   = hold;
         @(posedge clk);
         if (!hold) begin
            @(negedge clk);
            req_valid = 1'b0;
         end
      endtask

      initial begin : stim
         logic        wr;
         logic [2:0]  f3;
         logic [31:0] addr;
         int          k, n;
         reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'h0;
         req_addr = 32'h0; req_wdata = 32'h0;
         repeat (3) @(negedge clk);
         check("rst_req_ready", gi, 32'(req_ready), 32'd1);
         check("rst_resp_valid", gi, 32'(resp_valid), 32'd0);
         check("rst_resp_rdata", gi, resp_rdata, 32'd0);
         check("rst_resp_fault", gi, 32'(resp_fault), 32'd0);
         check("rst_mem_en", gi, 32'(mem_en), 32'd0);
         check("rst_mem_we", gi, 32'(mem_we), 32'd0);
         check("rst_mem_be", gi, 32'(mem_be), 32'd0);
         check("rst_mem_addr", gi, 32'(mem_addr), 32'd0);
         check("rst_mem_wdata", gi, mem_wdata, 32'd0);
         reset = 1'b0;

         for (int w = 0; w < 16; w++)
            issue(1'b1, F3_SW, 32'(w * 4), (w == 1) ? 32'h884422F1 : $urandom, 1'b0);

         issue(1'b0, F3_LB,  32'h4, 32'h0, 1'b0);
         issue(1'b0, F3_LBU, 32'h7, 32'h0, 1'b0);
         issue(1'b0, F3_LH,  32'h6, 32'h0, 1'b0);
         issue(1'b0, F3_LW,  32'h4, 32'h0, 1'b0);
         issue(1'b1, F3_SB,  32'h9, 32'h123456AB, 1'b0);
         issue(1'b0, F3_LW,  32'h8, 32'h0, 1'b0);
         issue(1'b0, F3_LW,  32'h6, 32'h0, 1'b0);
         issue(1'b1, F3_SH,  32'h3, 32'h5555, 1'b0);
         issue(1'b0, 3'b011, 32'h8, 32'h0, 1'b0);
         issue(1'b1, 3'b100, 32'h8, 32'h77, 1'b0);
         issue(1'b1, F3_SW,  32'h10, $urandom, 1'b1);
         issue(1'b0, F3_LW,  32'h10, 32'h0, 1'b1);
         issue(1'b0, F3_LB,  32'h11, 32'h0, 1'b0);

         // Reset during the load wait: response must vanish, unit returns to IDLE.
         issue(1'b0, F3_LW, 32'h4, 32'h0, 1'b0);
         while (cyc < last_accept + RST_OFF) @(negedge clk);
         reset = 1'b1;
         resp_q.delete();
         @(negedge clk);
         check("wait_rst_ready", gi, 32'(req_ready), 32'd1);
         check("wait_rst_resp_valid", gi, 32'(resp_valid), 32'd0);
         reset = 1'b0;
         repeat (6) @(negedge clk);
         issue(1'b0, F3_LW, 32'h4, 32'h0, 1'b0);

         // Reset landing on the ISSUE cycle of a store must suppress the write.
         @(negedge clk);
         req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_SW;
         req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
         n = 0;
         while (!req_ready && n < 64) begin @(negedge clk); n++; end
         check("issue_rst_accept", gi, 32'(req_ready), 32'd1);
         @(posedge clk);
         #1;
         reset = 1'b1;
         req_valid = 1'b0;
         @(negedge clk);
         check("issue_rst_mem_en", gi, 32'(mem_en), 32'd0);
         check("issue_rst_mem_we", gi, 32'(mem_we), 32'd0);
         @(negedge clk);
         reset = 1'b0;
         issue(1'b0, F3_LW, 32'h4, 32'h0, 1'b0);

         for (int t = 0; t < 150; t++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
               f3 = 3'($urandom_range(0, 7));
            end else if (wr) begin
               f3 = 3'($urandom_range(0, 2));
            end else begin
               k  = $urandom_range(0, 4);
               f3 = (k < 3) ? 3'(k) : 3'(k + 1);
            end
            addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b00) addr[1:0] = 2'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b01) addr[1] = 1'($urandom_range(0, 1));
            issue(wr, f3, addr, $urandom, (t < 149) ? 1'($urandom_range(0, 1)) : 1'b0);
         end

         repeat (10) @(negedge clk);
         check("resp_drain", gi, 32'(resp_q.size()), 32'd0);
         check("mem_drain", gi, 32'(mem_q.size()), 32'd0);
         check("mem_count", gi, 32'(mem_seen), 32'(mem_expected));
         done = 1'b1;
      end
   end

   initial begin : finish_ctl
      int n;
      n = 0;
      while (!(g_inst[0].done && g_inst[1].done) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("sim_done", 0, {30'h0, g_inst[1].done, g_inst[0].done}, 32'd3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
